// File: rtl/jtframe_ddram_bram_resp_if.sv
// jtframe_ddram_bram_resp_if: 64-bit burst DDR request/response bus plus status port.
interface jtframe_ddram_bram_resp_if;
  logic        ddram_busy;
  logic [7:0]  ddram_burstcnt;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        ddram_rd;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_we;
  logic [7:0]  st_addr;
  logic [7:0]  st_dout;
  modport master (
    input  ddram_busy, ddram_dout, ddram_dout_ready, st_dout,
    output ddram_burstcnt, ddram_addr, ddram_rd, ddram_din, ddram_be, ddram_we, st_addr
  );
  modport slave (
    output ddram_busy, ddram_dout, ddram_dout_ready, st_dout,
    input  ddram_burstcnt, ddram_addr, ddram_rd, ddram_din, ddram_be, ddram_we, st_addr
  );
endinterface

// File: rtl/jtframe_ddram_bram_resp.sv
// jtframe_ddram_bram_resp: BRAM-backed DDR burst responder with latency, write stall and status counters.
module jtframe_ddram_bram_resp #(
  parameter int AW      = 12,
  parameter int RD_LAT  = 3,
  parameter int STALL_N = 0
) (
  input logic clk,
  input logic rst,
  jtframe_ddram_bram_resp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_DATA} state_t;
  localparam logic [3:0]  WLAT  = 4'(RD_LAT - 2);
  localparam logic [15:0] SLAST = STALL_N > 0 ? 16'(STALL_N - 1) : 16'd0;
  state_t state, state_nx;
  logic [63:0] mem [0:2**AW-1];
  logic [63:0] dout;
  logic [AW-1:0] ptr, waddr;
  logic [7:0] rem, bc, rd_cnt, wr_cnt, err_cnt, err_inc, st_dout;
  logic [3:0] wcnt;
  logic [15:0] scnt;
  logic stall, busy, acc_we, acc_rd, beat, wr_last, rd_done, bc0, dout_ready;
  assign busy = stall | state == RD_WAIT | state == RD_DATA;
  assign bus.ddram_busy = busy;
  assign bus.ddram_dout = dout;
  assign bus.ddram_dout_ready = dout_ready;
  assign bus.st_dout = st_dout;
  always_comb begin
    bc0      = bus.ddram_burstcnt == 8'd0;
    bc       = bc0 ? 8'd1 : bus.ddram_burstcnt;
    acc_we   = bus.ddram_we && !busy;
    acc_rd   = bus.ddram_rd && !bus.ddram_we && !busy && state == IDLE;
    waddr    = state == IDLE ? bus.ddram_addr[AW-1:0] : ptr;
    wr_last  = state == IDLE ? bc == 8'd1 : rem == 8'd1;
    beat     = (state == RD_WAIT && wcnt == 4'd0) || (state == RD_DATA && rem != 8'd0);
    rd_done  = state == RD_DATA && rem == 8'd0;
    // a simultaneous rd+we and a zero burst length are separate violations
    err_inc  = 8'(state == IDLE && bus.ddram_rd && bus.ddram_we && !busy)
             + 8'(state == IDLE && (acc_we || acc_rd) && bc0)
             + 8'(state == WR && bus.ddram_rd && !busy);
    state_nx = state == IDLE    ? (acc_we ? (wr_last ? IDLE : WR) : acc_rd ? RD_WAIT : IDLE) :
               state == WR      ? (acc_we && wr_last ? IDLE : WR) :
               state == RD_WAIT ? (wcnt == 4'd0 ? RD_DATA : RD_WAIT) :
                                  (rem == 8'd0 ? IDLE : RD_DATA);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (acc_we && !rst)
      for (int i = 0; i < 8; i++)
        if (bus.ddram_be[i]) mem[waddr][8*i +: 8] <= bus.ddram_din[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= 64'd0;
      dout_ready <= 1'b0;
      rd_cnt     <= 8'd0;
      wr_cnt     <= 8'd0;
      err_cnt    <= 8'd0;
      stall      <= 1'b0;
      scnt       <= 16'd0;
      st_dout    <= 8'd0;
      ptr        <= '0;
      rem        <= 8'd0;
      wcnt       <= 4'd0;
    end else begin
      dout_ready <= beat;
      stall      <= 1'b0;
      err_cnt    <= err_cnt + err_inc;
      if (acc_we) begin
        ptr <= waddr + 1'b1;
        rem <= state == IDLE ? bc - 8'd1 : rem - 8'd1;
        if (wr_last) wr_cnt <= wr_cnt + 8'd1;
        if (STALL_N > 0) begin
          scnt  <= scnt == SLAST ? 16'd0 : scnt + 16'd1;
          stall <= scnt == SLAST;
        end
      end
      if (acc_rd) begin
        ptr  <= bus.ddram_addr[AW-1:0];
        rem  <= bc;
        wcnt <= WLAT;
      end
      if (state == RD_WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
      if (beat) begin
        dout <= mem[ptr];
        ptr  <= ptr + 1'b1;
        rem  <= rem - 8'd1;
      end
      if (rd_done) rd_cnt <= rd_cnt + 8'd1;
      st_dout <= bus.st_addr == 8'd0 ? rd_cnt :
                 bus.st_addr == 8'd1 ? wr_cnt :
                 bus.st_addr == 8'd2 ? err_cnt :
                 bus.st_addr == 8'd3 ? {state, 5'd0, busy} : 8'd0;
    end
  end
endmodule

// File: tb/tb_jtframe_ddram_bram_resp.sv
// tb_jtframe_ddram_bram_resp: table vectors plus hand sequences, read data checked through a scoreboard queue.
module tb_jtframe_ddram_bram_resp;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  jtframe_ddram_bram_resp_if bus();
  jtframe_ddram_bram_resp #(.AW(12), .RD_LAT(3), .STALL_N(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct { logic [28:0] a; logic [63:0] pre; logic [7:0] be; logic [63:0] din; logic [63:0] exp; } vec_t;
  int total = 0, bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model[int];
  logic [63:0] wd[0:7];
  vec_t vt[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.ddram_dout_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got %h want no beat", bus.ddram_dout);
      end else chk("rd_data", bus.ddram_dout, exp_q.pop_front());
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic void model_write(input int a, input logic [7:0] be, input logic [63:0] d);
    logic [63:0] w = model.exists(a) ? model[a] : 64'd0;
    for (int i = 0; i < 8; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    model[a] = w;
  endfunction
  function automatic void push_model(input int a, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(model[(a + k) % 4096]);
  endfunction
  task automatic wr_burst(input int a, input int n, input logic [7:0] be);
    int i = 0, g = 0;
    bus.ddram_we = 1'b1;
    bus.ddram_addr = 29'(a);
    bus.ddram_burstcnt = 8'(n);
    bus.ddram_be = be;
    while (i < n && g < 100) begin
      bus.ddram_din = wd[i];
      @(negedge clk);
      if (!bus.ddram_busy) begin
        model_write((a + i) % 4096, be, wd[i]);
        i++;
      end
      tick;
      g++;
    end
    bus.ddram_we = 1'b0;
    chk("wr_beats", i, n);
  endtask
  task automatic accept_rd(input int a, input int n);
    int g = 0;
    bus.ddram_rd = 1'b1;
    bus.ddram_addr = 29'(a);
    bus.ddram_burstcnt = 8'(n);
    @(negedge clk);
    while (bus.ddram_busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    tick;
    bus.ddram_rd = 1'b0;
  endtask
  task automatic drain;
    int g = 0;
    while ((exp_q.size() != 0 || bus.ddram_busy) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_left", exp_q.size(), 0);
    tick;
  endtask
  task automatic st_chk(input string name, input logic [7:0] sel, input logic [7:0] exp);
    bus.st_addr = sel;
    tick;
    chk(name, bus.st_dout, exp);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    logic [6:0] pat;
    int i;
    vt[0] = '{29'h020, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 64'hFFFFFFFF_BBBBBBBB};
    vt[1] = '{29'h021, 64'h0,                 8'hF0, 64'hAAAAAAAA_BBBBBBBB, 64'hAAAAAAAA_00000000};
    vt[2] = '{29'h022, 64'h01234567_89ABCDEF, 8'h81, 64'hFFFFFFFF_FFFFFFFF, 64'hFF234567_89ABCDFF};
    vt[3] = '{29'h023, 64'h01234567_89ABCDEF, 8'h00, 64'h0,                 64'h01234567_89ABCDEF};
    vt[4] = '{29'h024, 64'h0,                 8'h55, 64'h11223344_55667788, 64'h00220044_00660088};
    bus.ddram_rd = 0; bus.ddram_we = 0; bus.ddram_addr = 0; bus.ddram_burstcnt = 1;
    bus.ddram_be = 8'hFF; bus.ddram_din = 0; bus.st_addr = 0;
    repeat (3) tick;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.ddram_busy, 0);
    chk("rst_ready", bus.ddram_dout_ready, 0);
    chk("rst_dout", bus.ddram_dout, 0);
    tick;
    for (int s = 0; s < 4; s++) st_chk("rst_st", 8'(s), 8'd0);
    // 4-beat write then timed 4-beat read
    wd[0] = {2{32'h11111111}}; wd[1] = {2{32'h22222222}};
    wd[2] = {2{32'h33333333}}; wd[3] = {2{32'h44444444}};
    wr_burst(16, 4, 8'hFF);
    tick;
    push_model(16, 4);
    bus.ddram_rd = 1'b1; bus.ddram_addr = 29'h10; bus.ddram_burstcnt = 8'd4;
    @(negedge clk);
    chk("rd_acc_busy", bus.ddram_busy, 0);
    tick;
    bus.ddram_rd = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("rd_ready_t", bus.ddram_dout_ready, (k >= 3 && k <= 6) ? 1 : 0);
      chk("rd_busy_t", bus.ddram_busy, k <= 6 ? 1 : 0);
    end
    tick;
    chk("dout_hold", bus.ddram_dout, {2{32'h44444444}});
    st_chk("wr_cnt1", 8'd1, 8'd1);
    st_chk("rd_cnt1", 8'd0, 8'd1);
    // byte-enable table
    for (int v = 0; v < 5; v++) begin
      wd[0] = vt[v].pre;
      wr_burst(int'(vt[v].a), 1, 8'hFF);
      wd[0] = vt[v].din;
      wr_burst(int'(vt[v].a), 1, vt[v].be);
      exp_q.push_back(vt[v].exp);
      accept_rd(int'(vt[v].a), 1);
      drain;
    end
    // address wrap at top of memory
    wd[0] = 64'hC0FFEE00_00000001; wd[1] = 64'hC0FFEE00_00000002; wd[2] = 64'hC0FFEE00_00000003;
    wr_burst(4095, 3, 8'hFF);
    push_model(4095, 3);
    accept_rd(4095, 3);
    drain;
    exp_q.push_back(64'hC0FFEE00_00000002);
    exp_q.push_back(64'hC0FFEE00_00000003);
    accept_rd(0, 2);
    drain;
    // write stall every 2 beats
    do_reset;
    for (int k = 0; k < 5; k++) wd[k] = 64'h5A5A0000_00000000 + 64'(k);
    pat = 7'b0100100;
    i = 0;
    bus.ddram_we = 1'b1; bus.ddram_addr = 29'h80; bus.ddram_burstcnt = 8'd5; bus.ddram_be = 8'hFF;
    for (int c = 0; c < 7; c++) begin
      bus.ddram_din = wd[i < 5 ? i : 4];
      @(negedge clk);
      chk("stall_busy", bus.ddram_busy, pat[c]);
      if (!bus.ddram_busy && i < 5) begin
        model_write(128 + i, 8'hFF, wd[i]);
        i++;
      end
      tick;
    end
    bus.ddram_we = 1'b0;
    chk("stall_beats", i, 5);
    st_chk("stall_state", 8'd3, 8'd0);
    st_chk("stall_wr_cnt", 8'd1, 8'd1);
    push_model(128, 5);
    accept_rd(128, 5);
    drain;
    // rd+we collision, then zero-length read
    do_reset;
    wd[0] = 64'hDEADBEEF_12345678;
    bus.ddram_rd = 1'b1;
    wr_burst(64, 1, 8'hFF);
    bus.ddram_rd = 1'b0;
    st_chk("err_cnt1", 8'd2, 8'd1);
    exp_q.push_back(64'hDEADBEEF_12345678);
    accept_rd(64, 0);
    drain;
    repeat (5) tick;
    st_chk("err_cnt2", 8'd2, 8'd2);
    st_chk("zero_rd_cnt", 8'd0, 8'd1);
    st_chk("coll_wr_cnt", 8'd1, 8'd1);
    // reset during the second beat of an 8-beat read
    for (int k = 0; k < 8; k++) wd[k] = 64'h0BAD0000_00000000 + 64'(k * 3);
    wr_burst(16, 8, 8'hFF);
    tick;
    push_model(16, 8);
    accept_rd(16, 8);
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_beats_left", exp_q.size(), 6);
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_ready", bus.ddram_dout_ready, 0);
    chk("mid_rst_busy", bus.ddram_busy, 0);
    tick;
    st_chk("mid_rst_rd", 8'd0, 8'd0);
    st_chk("mid_rst_wr", 8'd1, 8'd0);
    st_chk("mid_rst_err", 8'd2, 8'd0);
    push_model(16, 4);
    accept_rd(16, 4);
    drain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtframe_ddram_bram_resp.md
Name: jtframe_ddram_bram_resp

Overview:
- Responder end of the 64-bit burst DDR interface that the line/frame buffer controllers drive (ddram_rd/we/addr/burstcnt/be/din in, ddram_busy/dout/dout_ready out).
- Backs the interface with on-chip block RAM.
- Lets frame-buffer cores run on boards without DDR, and gives simulation benches a cycle-exact memory model with programmable latency and back-pressure.
- Also exposes protocol-violation and traffic counters on the standard st_addr/st_dout status port.

Parameters:
- AW, 12, word-address bits actually stored; memory depth is 2^AW words of 64 bits.
- RD_LAT, 3, cycles from read acceptance to the first dout_ready beat. Legal range 2..15.
- STALL_N, 0, inserts one busy cycle after every STALL_N accepted write beats. 0 = never stall.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- ddram_busy  out  1  back-pressure; a request or beat is accepted only while low.
- ddram_burstcnt  in  8  burst length, sampled on the first accepted beat or the read request.
- ddram_addr  in  29  64-bit word address; the low AW bits are used.
- ddram_dout  out  64  read data.
- ddram_dout_ready  out  1  read data valid, one beat per cycle.
- ddram_rd  in  1  read request.
- ddram_din  in  64  write data.
- ddram_be  in  8  byte enables for ddram_din; bit n covers byte n.
- ddram_we  in  1  write beat valid.
- st_addr  in  8  status register select.
- st_dout  out  8  status register data.

Behaviour:
- Acceptance: a command or beat is accepted on a rising edge where (rd or we) is high and busy is low.
- Reset: on rst high at an edge, state goes to IDLE. busy=0, dout_ready=0, dout=0, and all counters are cleared. Memory contents are preserved. A reset mid-burst abandons the burst with no further beats.
- States: IDLE, WR, RD_WAIT, RD_DATA.
- IDLE, we accepted:
  - Write beat 0 to addr[AW-1:0] under be.
  - Latch the address and remaining = burstcnt-1.
  - If remaining=0, stay in IDLE; otherwise go to WR.
- IDLE, rd accepted (we low):
  - Latch the address and burstcnt; go to RD_WAIT.
  - busy goes high the next cycle.
- IDLE, rd and we both high: the write wins, the read is dropped, and err_cnt increments.
- burstcnt=0 on any command is treated as 1, and err_cnt increments.
- WR:
  - Each accepted we beat writes to the next address (increment modulo 2^AW) and decrements remaining.
  - After the beat with remaining=0, go to IDLE. busy stays low, so a new command is accepted the very next cycle.
  - rd high in WR is ignored and increments err_cnt.
  - Cycles with we low simply wait; there is no timeout.
- Write stall: when STALL_N>0, busy is high for exactly one cycle after every STALL_N-th accepted write beat, counted across bursts. A beat presented during that cycle is not accepted.
- Reads:
  - Request accepted at edge T → busy high from cycle T+1.
  - First dout_ready at cycle T+RD_LAT.
  - Beats are consecutive, with the address incrementing modulo 2^AW.
  - After the last beat, busy is low in the following cycle and the state returns to IDLE.
  - dout holds its last value while dout_ready is low.
- Read-after-write: a read issued the cycle after the last write beat returns the new data. The BRAM is written before the read pipeline samples it.
- Counters (8-bit, wrapping at 255→0):
  - rd_cnt increments per read burst completed.
  - wr_cnt increments per write burst completed.
  - err_cnt increments per violation.
- st_dout is registered, one cycle after st_addr:
  - 0 → rd_cnt
  - 1 → wr_cnt
  - 2 → err_cnt
  - 3 → {state[1:0], 5'd0, busy}
  - other values → 0

Test Plan:
- Reset then idle → busy=0, dout_ready=0, st_dout=0 for st_addr 0..3 except bit0 reflects busy=0.
- Write burst of 4 at addr 0x10, din=0x1111…,0x2222…,0x3333…,0x4444…, be=FF, then read burst of 4 at 0x10 with RD_LAT=3 → dout_ready high at T+3..T+6 with the same four words in order, busy low at T+7, wr_cnt=1, rd_cnt=1.
- Single write with be=0x0F of 0xAAAAAAAA_BBBBBBBB over a preset word 0xFFFFFFFF_FFFFFFFF → read returns 0xFFFFFFFF_BBBBBBBB.
- Burst of 3 starting at 2^AW-1 → the words land at 2^AW-1, 0, 1; the read back matches.
- STALL_N=2, burst of 5 with we held high → busy pulses after beats 2 and 4; exactly 5 words written; the burst completes in 7 cycles.
- rd and we asserted together in IDLE, then burstcnt=0 read → the write is performed, the read is dropped, the second read returns 1 beat, and err_cnt=2.
- Assert rst on the second beat of an 8-beat read → dout_ready low from the next cycle, busy=0, counters 0, and memory data is still readable afterwards.
